hid_report_queue: RTL and testbench

Buffers and sequences HID reports from the USB HID host core toward a single slow consumer, such as the UART HID printer, through a valid/ready handshake. Each report pulse captures a typed snapshot into a small FIFO. A full queue coalesces mouse reports and drops other reports, counting the drops. Connection-error rising edges are also queued as status events, so the consumer never misses a report while it is busy transmitting.

---
 rtl/hid_pkg.sv | 60 ++++++
 rtl/sat_add_s8.sv | 21 ++
 rtl/hid_report_queue.sv | 153 +++++++++++++++
 tb/tb_hid_report_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hid_pkg.sv
// Shared types and payload layout for the HID report queue.
// The consumer and the queue agree on the field offsets defined here.
package hid_pkg;

  typedef enum logic [1:0] {
    TYP_NONE  = 2'd0,
    TYP_KBD   = 2'd1,
    TYP_MOUSE = 2'd2,
    TYP_GAME  = 2'd3
  } hid_typ_e;

  localparam int PAYLOAD_W = 48;

  localparam int KBD_MOD_OFS   = 40;
  localparam int KBD_K1_OFS    = 32;
  localparam int KBD_K2_OFS    = 24;
  localparam int KBD_K3_OFS    = 16;
  localparam int KBD_K4_OFS    = 8;
  localparam int MOUSE_BTN_OFS = 40;
  localparam int MOUSE_DX_OFS  = 32;
  localparam int MOUSE_DY_OFS  = 24;
  localparam int GAME_BTN_OFS  = 36;

  // Gamepad button bit positions inside game_btn, u at bit 0.
  typedef enum int {
    GAME_U   = 0,
    GAME_D   = 1,
    GAME_L   = 2,
    GAME_R   = 3,
    GAME_A   = 4,
    GAME_B   = 5,
    GAME_X   = 6,
    GAME_Y   = 7,
    GAME_SEL = 8,
    GAME_STA = 9,
    GAME_SHL = 10,
    GAME_SHR = 11
  } game_bit_e;

  localparam int GAME_BTN_W = int'(GAME_SHR) + 1;

  typedef struct packed {
    logic [1:0]           typ;
    logic [PAYLOAD_W-1:0] data;
  } hid_entry_t;

  function automatic logic [PAYLOAD_W-1:0] mouse_payload(
    input logic [7:0] btn,
    input logic [7:0] dx,
    input logic [7:0] dy
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[MOUSE_BTN_OFS +: 8] = btn;
    p[MOUSE_DX_OFS  +: 8] = dx;
    p[MOUSE_DY_OFS  +: 8] = dy;
    return p;
  endfunction

endpackage

// File: rtl/sat_add_s8.sv
// Signed 8-bit adder that clamps the result to -128..127.
module sat_add_s8 (
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  output logic signed [7:0] sum
);

  logic signed [8:0] wide;

  assign wide = a + b;

  // A 9-bit result whose top two bits differ has left the 8-bit range.
  always_comb begin
    if (wide[8] != wide[7]) begin
      sum = wide[8] ? 8'sh80 : 8'sh7f;
    end else begin
      sum = wide[7:0];
    end
  end

endmodule

// File: rtl/hid_report_queue.sv
// Small FIFO of typed HID report snapshots and connection-error events,
// drained by one slow consumer over a valid/ready handshake.
module hid_report_queue
  import hid_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 usbclk,
  input  logic                 usbrst_n,
  input  logic [1:0]           typ,
  input  logic                 report,
  input  logic                 conerr,
  input  logic [7:0]           key_modifiers,
  input  logic [7:0]           key1,
  input  logic [7:0]           key2,
  input  logic [7:0]           key3,
  input  logic [7:0]           key4,
  input  logic [7:0]           mouse_btn,
  input  logic [7:0]           mouse_dx,
  input  logic [7:0]           mouse_dy,
  input  logic [11:0]          game_btn,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [1:0]           ev_typ,
  output logic [PAYLOAD_W-1:0] ev_data,
  output logic [PTR_W:0]       level,
  output logic [7:0]           drop_cnt
);

  hid_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             conerr_q;
  logic             conerr_pend;

  logic             full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic             coalesce;
  logic             drop;
  logic             status_wr;
  logic             advance;
  hid_entry_t       new_entry;
  logic [7:0]       sum_dx;
  logic [7:0]       sum_dy;

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  hid_entry_t       mem_wdata;

  assign full     = (level == (PTR_W+1)'(DEPTH));
  assign ev_valid = (level != '0);
  assign pop      = ev_valid && ev_ready;
  assign tail_ptr = wr_ptr - PTR_W'(1);

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push_req  = report && (typ != TYP_NONE);
  assign push_ok   = push_req && (!full || pop);
  assign coalesce  = push_req && full && !pop && (typ == TYP_MOUSE)
                     && (mem[tail_ptr].typ == TYP_MOUSE);
  assign drop      = push_req && full && !pop && !coalesce;
  assign status_wr = conerr_pend && !push_req && (!full || pop);
  assign advance   = push_ok || status_wr;

  assign ev_typ  = ev_valid ? mem[rd_ptr].typ  : 2'b00;
  assign ev_data = ev_valid ? mem[rd_ptr].data : '0;

  sat_add_s8 u_sat_dx (
    .a   (mem[tail_ptr].data[MOUSE_DX_OFS +: 8]),
    .b   (mouse_dx),
    .sum (sum_dx)
  );

  sat_add_s8 u_sat_dy (
    .a   (mem[tail_ptr].data[MOUSE_DY_OFS +: 8]),
    .b   (mouse_dy),
    .sum (sum_dy)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    new_entry      = '0;
    new_entry.typ  = typ;
    case (typ)
      TYP_KBD: begin
        new_entry.data[KBD_MOD_OFS +: 8] = key_modifiers;
        new_entry.data[KBD_K1_OFS  +: 8] = key1;
        new_entry.data[KBD_K2_OFS  +: 8] = key2;
        new_entry.data[KBD_K3_OFS  +: 8] = key3;
        new_entry.data[KBD_K4_OFS  +: 8] = key4;
      end
      TYP_MOUSE: new_entry.data = mouse_payload(mouse_btn, mouse_dx, mouse_dy);
      TYP_GAME:  new_entry.data[GAME_BTN_OFS +: GAME_BTN_W] = game_btn;
      default:   new_entry.data = '0;
    endcase
  end

  // Single write port shared by normal push, tail coalesce and status events.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    mem_wdata = '0;
    if (push_ok) begin
      mem_we    = 1'b1;
      mem_wdata = new_entry;
    end else if (coalesce) begin
      mem_we         = 1'b1;
      mem_waddr      = tail_ptr;
      mem_wdata.typ  = TYP_MOUSE;
      mem_wdata.data = mouse_payload(mouse_btn, sum_dx, sum_dy);
    end else if (status_wr) begin
      mem_we    = 1'b1;
      mem_wdata = '0;
    end
  end

  // NOTE: storage has no reset; level gates every read, so stale contents are never visible.
  always_ff @(posedge usbclk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge usbclk or negedge usbrst_n) begin
    if (!usbrst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      drop_cnt    <= '0;
      conerr_q    <= 1'b0;
      conerr_pend <= 1'b0;
    end else begin
      conerr_q    <= conerr;
      // A fresh edge while one is pending merges into the same event.
      conerr_pend <= (conerr && !conerr_q) || (conerr_pend && !status_wr);
      if (advance) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level + {{PTR_W{1'b0}}, advance} - {{PTR_W{1'b0}}, pop};
      if (drop && (drop_cnt != 8'hff)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hid_report_queue.sv
// Directed bench for hid_report_queue: fill, drop, coalesce, status events,
// asynchronous reset and drop counter saturation.
module tb_hid_report_queue;

  logic        usbclk;
  logic        usbrst_n;
  logic [1:0]  typ;
  logic        report;
  logic        conerr;
  logic [7:0]  key_modifiers, key1, key2, key3, key4;
  logic [7:0]  mouse_btn, mouse_dx, mouse_dy;
  logic [11:0] game_btn;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_typ;
  logic [47:0] ev_data;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  hid_report_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .usbclk        (usbclk),
    .usbrst_n      (usbrst_n),
    .typ           (typ),
    .report        (report),
    .conerr        (conerr),
    .key_modifiers (key_modifiers),
    .key1          (key1),
    .key2          (key2),
    .key3          (key3),
    .key4          (key4),
    .mouse_btn     (mouse_btn),
    .mouse_dx      (mouse_dx),
    .mouse_dy      (mouse_dy),
    .game_btn      (game_btn),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_typ        (ev_typ),
    .ev_data       (ev_data),
    .level         (level),
    .drop_cnt      (drop_cnt)
  );

  initial usbclk = 1'b0;
  always #5 usbclk = ~usbclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge usbclk);
    #1;
  endtask

  task automatic do_reset();
    usbrst_n = 1'b0;
    #3;
    usbrst_n = 1'b1;
    tick();
  endtask

  task automatic push_kbd(input logic [7:0] m, input logic [7:0] a, input logic [7:0] b);
    typ = 2'd1; key_modifiers = m; key1 = a; key2 = b; key3 = 8'h00; key4 = 8'h00;
    report = 1'b1;
    tick();
    report = 1'b0;
  endtask

  task automatic push_game(input logic [11:0] g);
    typ = 2'd3; game_btn = g; report = 1'b1;
    tick();
    report = 1'b0;
  endtask

  task automatic push_mouse(input logic [7:0] b, input logic [7:0] dx, input logic [7:0] dy);
    typ = 2'd2; mouse_btn = b; mouse_dx = dx; mouse_dy = dy; report = 1'b1;
    tick();
    report = 1'b0;
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  initial begin
    usbrst_n = 1'b0; typ = 2'd0; report = 1'b0; conerr = 1'b0; ev_ready = 1'b0;
    key_modifiers = '0; key1 = '0; key2 = '0; key3 = '0; key4 = '0;
    mouse_btn = '0; mouse_dx = '0; mouse_dy = '0; game_btn = '0;
    #12;
    usbrst_n = 1'b1;
    tick();

    // 1: reset state, then single keyboard report
    check("rst_valid", ev_valid, 0);
    check("rst_level", level, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_typ", ev_typ, 0);
    check("rst_data", ev_data, 0);
    push_kbd(8'h02, 8'h04, 8'h05);
    check("t1_valid", ev_valid, 1);
    check("t1_typ", ev_typ, 1);
    check("t1_data", ev_data, 48'h02_04_05_00_00_00);
    check("t1_level", level, 1);

    // 2: fill with gamepads, drop a keyboard report, pop once
    do_reset();
    push_game(12'h001); push_game(12'h002); push_game(12'h004); push_game(12'h008);
    check("t2_full", level, 4);
    push_kbd(8'h77, 8'h00, 8'h00);
    check("t2_level", level, 4);
    check("t2_drop", drop_cnt, 1);
    check("t2_head_typ", ev_typ, 3);
    check("t2_head", ev_data, 48'h001_000000000);
    typ = 2'd0; report = 1'b1; tick(); report = 1'b0;
    check("t2_typ0_nodrop", drop_cnt, 1);
    pop_one();
    check("t2_pop_level", level, 3);
    check("t2_second", ev_data, 48'h002_000000000);

    // 3: mouse coalescing into the tail with saturation
    do_reset();
    push_kbd(8'h01, 8'h00, 8'h00); push_kbd(8'h02, 8'h00, 8'h00); push_kbd(8'h03, 8'h00, 8'h00);
    push_mouse(8'h00, 8'h64, 8'h9c);
    push_mouse(8'h01, 8'h64, 8'hce);
    check("t3_level", level, 4);
    check("t3_drop", drop_cnt, 0);
    check("t3_head_kept", ev_data, 48'h01_00_00_00_00_00);
    pop_one(); pop_one(); pop_one();
    check("t3_tail_typ", ev_typ, 2);
    check("t3_tail_data", ev_data, 48'h01_7f_80_000000);

    // 4: push and pop in the same cycle while full
    push_kbd(8'h11, 8'h00, 8'h00); push_kbd(8'h22, 8'h00, 8'h00); push_kbd(8'h33, 8'h00, 8'h00);
    check("t4_full", level, 4);
    ev_ready = 1'b1;
    push_kbd(8'h44, 8'h00, 8'h00);
    ev_ready = 1'b0;
    check("t4_level", level, 4);
    check("t4_drop", drop_cnt, 0);
    check("t4_head", ev_data, 48'h11_00_00_00_00_00);
    pop_one(); pop_one(); pop_one();
    check("t4_last", ev_data, 48'h44_00_00_00_00_00);

    // 5: conerr alongside a mouse report, then conerr while full
    do_reset();
    conerr = 1'b1;
    push_mouse(8'h05, 8'h01, 8'h02);
    check("t5_first_level", level, 1);
    check("t5_first_typ", ev_typ, 2);
    tick();
    check("t5_status_level", level, 2);
    pop_one();
    check("t5_status_valid", ev_valid, 1);
    check("t5_status_typ", ev_typ, 0);
    check("t5_status_data", ev_data, 0);
    pop_one();
    check("t5_empty", level, 0);
    conerr = 1'b0;
    push_kbd(8'h01, 8'h00, 8'h00); push_kbd(8'h02, 8'h00, 8'h00);
    push_kbd(8'h03, 8'h00, 8'h00); push_kbd(8'h04, 8'h00, 8'h00);
    conerr = 1'b1;
    tick(); tick(); tick();
    check("t5_pend_full", level, 4);
    pop_one();
    check("t5_pop_write", level, 4);
    pop_one(); pop_one(); pop_one();
    check("t5_full_status_level", level, 1);
    check("t5_full_status_typ", ev_typ, 0);
    check("t5_full_status_valid", ev_valid, 1);
    conerr = 1'b0;

    // 6: asynchronous reset mid-operation, then drop counter saturation
    do_reset();
    push_kbd(8'h01, 8'h00, 8'h00); push_kbd(8'h02, 8'h00, 8'h00);
    push_kbd(8'h03, 8'h00, 8'h00); push_kbd(8'h04, 8'h00, 8'h00);
    push_kbd(8'h05, 8'h00, 8'h00);
    pop_one();
    check("t6_pre_level", level, 3);
    check("t6_pre_drop", drop_cnt, 1);
    #2;
    usbrst_n = 1'b0;
    #1;
    check("t6_async_valid", ev_valid, 0);
    check("t6_async_level", level, 0);
    check("t6_async_drop", drop_cnt, 0);
    usbrst_n = 1'b1;
    tick();
    push_kbd(8'h01, 8'h00, 8'h00); push_kbd(8'h02, 8'h00, 8'h00);
    push_kbd(8'h03, 8'h00, 8'h00); push_kbd(8'h04, 8'h00, 8'h00);
    for (int i = 0; i < 254; i++) push_kbd(8'h09, 8'h00, 8'h00);
    check("t6_drop_254", drop_cnt, 254);
    for (int i = 0; i < 46; i++) push_kbd(8'h09, 8'h00, 8'h00);
    check("t6_drop_sat", drop_cnt, 255);
    check("t6_level_full", level, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
